fp_op_sequencer: RTL and testbench
==================================

// Module: fp_op_sequencer
// PURPOSE
//  Issue/sequencing controller for the single-precision FP datapath (register file + add/sub/mul/div + round_off).
//  Accepts one OP-FP instruction at a time from the integer pipeline over a valid/ready handshake.
//  Holds the instruction stable toward the datapath for the op's latency, then pulses the FP register-file write.
//  Flags illegal encodings without writing back; supports flush (abort) of an in-flight op.
// PARAMETERS
//  ADD_LAT  2  datapath cycles for fadd.s/fsub.s before result_fp is valid (>=1)
//  MUL_LAT  3  cycles for fmul.s (>=1)
//  DIV_LAT  8  cycles for fdiv.s (>=1)
//  CNT_W    4  latency counter width; must hold max(*_LAT)-1
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   synchronous reset, active-high
//  in_valid       in   1   instruction offered
//  in_instr       in   32  RISC-V OP-FP instruction
//  in_ready       out  1   sequencer can accept (IDLE only)
//  flush          in   1   abort in-flight op; no writeback
//  dp_instr       out  32  instruction held toward datapath (rs1/rs2/rd/rm/funct7)
//  dp_float_ctrl  out  1   datapath enable; high in EXEC and WB
//  dp_reg_write   out  1   FP regfile write strobe; one cycle, WB only
//  done_valid     out  1   one-cycle completion pulse (legal WB or ERR)
//  done_rd        out  5   dp_instr[11:7] of completing op
//  illegal        out  1   qualifies done_valid: op was illegal, nothing written
//  busy           out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, dp_instr=0, cnt=0; all outputs 0 except in_ready=1. Reset mid-op drops it, no write.
//  Legal: opcode[6:0]=7'b1010011, instr[31:29]=0, instr[26:25]=0 (fmt S), rm[14:12] not 3'b101/3'b110.
//  Op select {instr[28],instr[27]}: 00 add, 01 sub (ADD_LAT), 10 mul (MUL_LAT), 11 div (DIV_LAT).
//  FSM IDLE/EXEC/WB/ERR; accept = in_valid & in_ready (cycle 0); dp_instr <= in_instr on accept only.
//   IDLE -> EXEC on legal accept, cnt <= LAT-1; IDLE -> ERR on illegal accept.
//   EXEC: cnt==0 -> WB else cnt--. EXEC occupies cycles 1..LAT.
//   WB (cycle LAT+1): dp_reg_write=1, done_valid=1, illegal=0; -> IDLE.
//   ERR (cycle 1): done_valid=1, illegal=1, dp_float_ctrl=0, dp_reg_write=0; -> IDLE.
//  in_ready=1 only in IDLE; no back-to-back: throughput one op per LAT+2 cycles.
//  dp_reg_write, done_valid, illegal, dp_float_ctrl decoded from state (registered state, Moore).
//  flush: in EXEC/WB/ERR -> IDLE next cycle; same-cycle dp_reg_write and done_valid forced 0 (flush wins over WB).
//   flush in IDLE: in_ready forced 0 that cycle, nothing accepted. flush with rst: rst wins.
//  dp_instr holds last accepted value after completion (datapath sees stable rs1/rs2 while idle).
//  done_rd = dp_instr[11:7] whenever done_valid; f0 is a normal writable register.
// STRUCTURE
//  Shared header fp_ctrl_defs.vh: OPC_OP_FP, op-select codes (FOP_ADD..FOP_DIV), state encodings, RM_RSVD values.
//  One sub-module: fp_op_decode (combinational: instr -> legal, op[1:0], lat_m1[CNT_W-1:0]).
//  Top: FSM + counter + dp_instr register only.
// TESTING
//  T1 fadd.s f3,f1,f2 (0x002081D3) at c0 -> EXEC c1-c2, dp_reg_write & done_valid c3, done_rd=3, in_ready c4.
//  T2 fdiv.s f3,f1,f2 (0x182081D3) -> busy 9 cycles, single dp_reg_write at c9, dp_instr stable c1-c9.
//  T3 illegal fmt 0x022081D3 and rm=101 0x0020D1D3 -> done_valid&illegal at c1, dp_reg_write never high.
//  T4 fmul.s 0x102081D3, flush at c2 -> IDLE c3, no dp_reg_write/done_valid; next op accepted c3 normally.
//  T5 rst asserted at c2 of fdiv -> c3 all outputs reset, in_ready=1; flush same cycle as WB -> no write.
//  T6 in_valid held high with two ops -> second accepted only when in_ready=1 (c4 for fadd), no op lost.

Source files
------------

// File: rtl/fp_op_sequencer_pkg.sv
// Shared encodings for the FP issue sequencer: OP-FP opcode, op-select codes,
// FSM state encoding and the reserved rounding-mode values.
package fp_op_sequencer_pkg;

  localparam logic [6:0] OPC_OP_FP = 7'b1010011;

  // Reserved rm encodings (101, 110) are rejected as illegal.
  localparam logic [2:0] RM_RSVD0 = 3'b101;
  localparam logic [2:0] RM_RSVD1 = 3'b110;

  // Op select taken from {instr[28], instr[27]}.
  typedef enum logic [1:0] {
    FOP_ADD = 2'b00,
    FOP_SUB = 2'b01,
    FOP_MUL = 2'b10,
    FOP_DIV = 2'b11
  } fop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

endpackage

// File: rtl/fp_op_sequencer_decode.sv
// Combinational OP-FP decoder: legality check and latency selection.
// Only the instruction fields that matter for sequencing are brought in.
module fp_op_decode
  import fp_op_sequencer_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic [6:0]       opcode,    // instr[6:0]
  input  logic [4:0]       funct_hi,  // instr[31:27]
  input  logic [1:0]       fmt,       // instr[26:25]
  input  logic [2:0]       rm,        // instr[14:12]
  output logic             legal,
  output logic [CNT_W-1:0] lat_m1
);

  fop_e op;

  // Legality and counter preload; the FSM counts lat_m1 down to zero in EXEC.
  always_comb begin
    op     = fop_e'(funct_hi[1:0]);
    legal  = (opcode == OPC_OP_FP) && (funct_hi[4:2] == 3'b000) &&
             (fmt == 2'b00) && (rm != RM_RSVD0) && (rm != RM_RSVD1);
    lat_m1 = CNT_W'(ADD_LAT - 1);
    case (op)
      FOP_ADD, FOP_SUB: lat_m1 = CNT_W'(ADD_LAT - 1);
      FOP_MUL:          lat_m1 = CNT_W'(MUL_LAT - 1);
      FOP_DIV:          lat_m1 = CNT_W'(DIV_LAT - 1);
      default:          lat_m1 = CNT_W'(ADD_LAT - 1);
    endcase
  end

endmodule

// File: rtl/fp_op_sequencer.sv
// Issue/sequencing controller for the single-precision FP datapath.
// Accepts one OP-FP instruction at a time, holds it toward the datapath for
// the op latency, then pulses the FP register-file write (or reports illegal).
module fp_op_sequencer
  import fp_op_sequencer_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] dp_instr,
  output logic        dp_float_ctrl,
  output logic        dp_reg_write,
  output logic        done_valid,
  output logic [4:0]  done_rd,
  output logic        illegal,
  output logic        busy
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic               dec_legal;
  logic [CNT_W-1:0]   dec_lat_m1;
  logic               accept;

  fp_op_decode #(
    .ADD_LAT (ADD_LAT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_decode (
    .opcode   (in_instr[6:0]),
    .funct_hi (in_instr[31:27]),
    .fmt      (in_instr[26:25]),
    .rm       (in_instr[14:12]),
    .legal    (dec_legal),
    .lat_m1   (dec_lat_m1)
  );

  assign accept = in_valid & in_ready;

  // FSM, latency counter and held instruction; flush aborts any non-idle state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dp_instr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dp_instr <= in_instr;
            if (dec_legal) begin
              state <= ST_EXEC;
              cnt   <= dec_lat_m1;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_EXEC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            state <= ST_WB;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WB:   state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore outputs from registered state; flush suppresses completion that cycle.
  always_comb begin
    in_ready      = (state == ST_IDLE) && !flush;
    busy          = (state != ST_IDLE);
    dp_float_ctrl = (state == ST_EXEC) || (state == ST_WB);
    dp_reg_write  = (state == ST_WB) && !flush;
    done_valid    = ((state == ST_WB) || (state == ST_ERR)) && !flush;
    illegal       = (state == ST_ERR) && !flush;
    done_rd       = dp_instr[11:7];
  end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Self-checking bench for fp_op_sequencer: directed scenarios plus random
// traffic compared cycle by cycle against a transaction-timing reference model.
module tb_fp_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        flush;
  logic        in_ready;
  logic [31:0] dp_instr;
  logic        dp_float_ctrl;
  logic        dp_reg_write;
  logic        done_valid;
  logic [4:0]  done_rd;
  logic        illegal;
  logic        busy;

  always #5 clk = ~clk;

  fp_op_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_instr      (in_instr),
    .in_ready      (in_ready),
    .flush         (flush),
    .dp_instr      (dp_instr),
    .dp_float_ctrl (dp_float_ctrl),
    .dp_reg_write  (dp_reg_write),
    .done_valid    (done_valid),
    .done_rd       (done_rd),
    .illegal       (illegal),
    .busy          (busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: one outstanding transaction described by its accept
  // cycle, legality and latency.
  bit          m_busy  = 0;
  bit          m_legal = 0;
  int          m_start = 0;
  int          m_lat   = 0;
  logic [31:0] m_instr = '0;

  logic [42:0] exp_vec;
  logic [42:0] obs_vec;

  localparam logic [31:0] I_FADD  = 32'h002081D3;
  localparam logic [31:0] I_FDIV  = 32'h182081D3;
  localparam logic [31:0] I_FMUL  = 32'h102081D3;
  localparam logic [31:0] I_BFMT  = 32'h022081D3;
  localparam logic [31:0] I_BRM   = 32'h0020D1D3;
  localparam logic [31:0] I_FSUB  = 32'h08418253; // fsub.s f4,f3,f4

  function automatic bit ref_legal(input logic [31:0] i);
    return (i[6:0] == 7'h53) && (i[31:29] == 3'd0) && (i[26:25] == 2'd0) &&
           (i[14:12] != 3'd5) && (i[14:12] != 3'd6);
  endfunction

  function automatic int ref_lat(input logic [31:0] i);
    case (i[28:27])
      2'd0, 2'd1: return 2;
      2'd2:       return 3;
      default:    return 8;
    endcase
  endfunction

  // Completion happens LAT+1 cycles after accept (legal) or 1 cycle (illegal).
  function automatic bit m_fin();
    int k;
    k = cyc - m_start;
    return m_busy && (m_legal ? (k == m_lat + 1) : (k == 1));
  endfunction

  function automatic logic [42:0] ref_out();
    bit f, d;
    f = m_fin();
    d = f && !flush;
    return {(!m_busy && !flush), m_busy, (m_busy && m_legal),
            (d && m_legal), d, (d && !m_legal),
            (d ? m_instr[11:7] : 5'd0), m_instr};
  endfunction

  task automatic apply(input bit v, input logic [31:0] ins, input bit fl, input bit r);
    @(negedge clk);
    in_valid = v;
    in_instr = ins;
    flush    = fl;
    rst      = r;
    #1;
    exp_vec = ref_out();
    obs_vec = {in_ready, busy, dp_float_ctrl, dp_reg_write, done_valid, illegal,
               (done_valid ? done_rd : 5'd0), dp_instr};
  endtask

  // Advance the reference model with the inputs in force, then the clock.
  task automatic tick();
    bit f;
    f = m_fin();
    if (rst) begin
      m_busy  = 0;
      m_instr = '0;
    end else if (m_busy) begin
      if (flush || f) m_busy = 0;
    end else if (in_valid && !flush) begin
      m_busy  = 1;
      m_start = cyc;
      m_instr = in_instr;
      m_legal = ref_legal(in_instr);
      m_lat   = ref_lat(in_instr);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    apply(0, '0, 1, 1);
    tick();
    apply(0, '0, 0, 1);
    tick();
    apply(0, '0, 0, 0);
    n_vec++;
    if (obs_vec !== {1'b1, 5'b0, 5'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec, {1'b1, 5'b0, 5'b0, 32'h0});
    end
    tick();
  endtask

  task automatic test_fadd();
    int wb_at = -1;
    int rd_seen = -1;
    for (int rel = 0; rel < 6; rel++) begin
      apply(rel == 0, I_FADD, 0, 0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL fadd cyc=%0d got=%h exp=%h", rel, obs_vec, exp_vec);
      end
      if (dp_reg_write) begin
        wb_at = rel;
        rd_seen = int'(done_rd);
      end
      tick();
    end
    n_vec++;
    if (wb_at !== 3 || rd_seen !== 3) begin
      n_bad++;
      $display("FAIL fadd_wb_timing got=c%0d/rd%0d exp=c3/rd3", wb_at, rd_seen);
    end
  endtask

  task automatic test_fdiv();
    int writes = 0;
    int wb_at = -1;
    int busy_cnt = 0;
    for (int rel = 0; rel < 12; rel++) begin
      apply(rel == 0, I_FDIV, 0, 0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL fdiv cyc=%0d got=%h exp=%h", rel, obs_vec, exp_vec);
      end
      if (dp_reg_write) begin
        writes++;
        wb_at = rel;
      end
      if (busy) busy_cnt++;
      tick();
    end
    n_vec++;
    if (writes !== 1 || wb_at !== 9 || busy_cnt !== 9) begin
      n_bad++;
      $display("FAIL fdiv_timing got=w%0d@c%0d busy%0d exp=w1@c9 busy9", writes, wb_at, busy_cnt);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ops [2];
    int ill_at;
    int writes;
    ops[0] = I_BFMT;
    ops[1] = I_BRM;
    for (int t = 0; t < 2; t++) begin
      ill_at = -1;
      writes = 0;
      for (int rel = 0; rel < 3; rel++) begin
        apply(rel == 0, ops[t], 0, 0);
        n_vec++;
        if (obs_vec !== exp_vec) begin
          n_bad++;
          $display("FAIL illegal%0d cyc=%0d got=%h exp=%h", t, rel, obs_vec, exp_vec);
        end
        if (done_valid && illegal) ill_at = rel;
        if (dp_reg_write) writes++;
        tick();
      end
      n_vec++;
      if (ill_at !== 1 || writes !== 0) begin
        n_bad++;
        $display("FAIL illegal%0d_flag got=c%0d w%0d exp=c1 w0", t, ill_at, writes);
      end
    end
  endtask

  task automatic test_flush();
    int wb_at = -1;
    int writes = 0;
    for (int rel = 0; rel < 9; rel++) begin
      apply(rel == 0 || rel == 3, (rel == 3) ? I_FADD : I_FMUL, rel == 2, 0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL flush cyc=%0d got=%h exp=%h", rel, obs_vec, exp_vec);
      end
      if (dp_reg_write) begin
        writes++;
        wb_at = rel;
      end
      tick();
    end
    n_vec++;
    if (writes !== 1 || wb_at !== 6) begin
      n_bad++;
      $display("FAIL flush_abort got=w%0d@c%0d exp=w1@c6", writes, wb_at);
    end
  endtask

  task automatic test_reset_mid();
    int writes = 0;
    int rdy3 = 0;
    // fdiv reset at c2; then fadd at c4 flushed on its WB cycle (c7)
    for (int rel = 0; rel < 10; rel++) begin
      apply(rel == 0 || rel == 4, (rel == 4) ? I_FADD : I_FDIV, rel == 2 || rel == 7, rel == 2);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL rst_mid cyc=%0d got=%h exp=%h", rel, obs_vec, exp_vec);
      end
      if (rel == 3) rdy3 = in_ready;
      if (dp_reg_write || done_valid) writes++;
      tick();
    end
    n_vec++;
    if (rdy3 !== 1 || writes !== 0) begin
      n_bad++;
      $display("FAIL rst_mid_drop got=rdy%0d done%0d exp=rdy1 done0", rdy3, writes);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    int acc_at [$];
    int writes = 0;
    q.push_back(I_FADD);
    q.push_back(I_FSUB);
    for (int rel = 0; rel < 12; rel++) begin
      apply(q.size() != 0, (q.size() != 0) ? q[0] : 32'h0, 0, 0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", rel, obs_vec, exp_vec);
      end
      if (dp_reg_write) writes++;
      if (q.size() != 0 && in_ready) begin
        acc_at.push_back(rel);
        void'(q.pop_front());
      end
      tick();
    end
    n_vec++;
    if (acc_at.size() !== 2 || writes !== 2) begin
      n_bad++;
      $display("FAIL b2b_count got=acc%0d w%0d exp=acc2 w2", acc_at.size(), writes);
    end else if (acc_at[1] !== 4) begin
      n_bad++;
      n_vec++;
      $display("FAIL b2b_second_accept got=c%0d exp=c4", acc_at[1]);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    i[6:0] = 7'h53;
    if ($urandom_range(0, 3) != 0) begin
      i[31:29] = 3'd0;
      i[26:25] = 2'd0;
    end
    if ($urandom_range(0, 9) == 0) i[6:0] = 7'($urandom_range(0, 127));
    return i;
  endfunction

  task automatic test_random();
    bit v, fl, r;
    for (int n = 0; n < 800; n++) begin
      v  = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 99) == 0);
      apply(v, rand_instr(), fl, r);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    flush    = 1'b0;
    test_reset();
    test_fadd();
    test_fdiv();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
